// File: rtl/hazard_ctrl.sv
// Hazard and mult/div sequencing controller beside the ID stage.
// Decides advance/stall/flush each cycle and drives the iterative mult/div unit.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_md,
  input  logic        id_is_div,
  input  logic        id_reads_hilo,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        md_start,
  output logic        md_done,
  output logic        md_busy,
  output logic [15:0] stall_cycles
);

  typedef enum logic {
    RUN,
    MD_BUSY
  } state_t;

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] count;

  logic rs_hit;
  logic rt_hit;
  logic load_use;
  logic hilo_hz;
  logic stall;

  assign rs_hit   = id_uses_rs & (id_rs == ex_rt);
  assign rt_hit   = id_uses_rt & (id_rt == ex_rt);
  assign load_use = id_valid & ex_mem_read & (ex_rt != 5'd0)
                  & (rs_hit | rt_hit);

  assign md_busy = (state == MD_BUSY);
  assign hilo_hz = id_valid & (id_is_md | id_reads_hilo) & md_busy;
  assign stall   = load_use | hilo_hz;

  assign pc_write    = ~stall;
  assign ifid_write  = ~stall;
  assign idex_bubble = stall;
  // A taken branch under stall stays in ID and resolves again next cycle.
  assign ifid_flush  = branch_taken & ~stall;

  assign md_start = ~md_busy & id_valid & id_is_md & ~stall;
  assign md_done  = md_busy & (count == ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      count <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (md_start) begin
            count <= id_is_div ? DIV_N : MULT_N;
            state <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          count <= count - ONE;
          if (md_done) state <= RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: per-cycle expectations queued by the driver,
// compared by a negedge monitor.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_is_md;
  logic        id_is_div;
  logic        id_reads_hilo;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        branch_taken;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        md_start;
  logic        md_done;
  logic        md_busy;
  logic [15:0] stall_cycles;

  hazard_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_is_md     (id_is_md),
    .id_is_div    (id_is_div),
    .id_reads_hilo(id_reads_hilo),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_bubble  (idex_bubble),
    .ifid_flush   (ifid_flush),
    .md_start     (md_start),
    .md_done      (md_done),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  ctl;
    logic [15:0] sc;
    string       tag;
  } exp_t;

  exp_t        q[$];
  int          checks;
  int          errors;
  logic [15:0] sc_exp;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, "/ctl"},
          {25'd0, pc_write, ifid_write, idex_bubble, ifid_flush,
           md_start, md_done, md_busy},
          {25'd0, e.ctl});
      chk({e.tag, "/sc"}, {16'd0, stall_cycles}, {16'd0, e.sc});
    end
  end

  // Queue this cycle's expectation, then advance to just after the edge.
  task automatic step(input logic s, input logic f, input logic st,
                      input logic d, input logic b, input string tag);
    exp_t e;
    e.ctl = {~s, ~s, s, f, st, d, b};
    e.sc  = sc_exp;
    e.tag = tag;
    q.push_back(e);
    if (s && rst_n && sc_exp != 16'hFFFF) sc_exp = sc_exp + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid      = 1'b0;
    id_rs         = 5'd0;
    id_rt         = 5'd0;
    id_uses_rs    = 1'b0;
    id_uses_rt    = 1'b0;
    id_is_md      = 1'b0;
    id_is_div     = 1'b0;
    id_reads_hilo = 1'b0;
    ex_mem_read   = 1'b0;
    ex_rt         = 5'd0;
    branch_taken  = 1'b0;
  endtask

  task automatic load_use_on();
    id_valid    = 1'b1;
    id_rs       = 5'd8;
    id_uses_rs  = 1'b1;
    ex_mem_read = 1'b1;
    ex_rt       = 5'd8;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sc_exp = 16'd0;
    rst_n  = 1'b0;
    idle();
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, "reset");
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, "idle");

    load_use_on();
    step(1, 0, 0, 0, 0, "lu_rs");
    ex_mem_read = 1'b0;
    step(0, 0, 0, 0, 0, "lu_clear");
    ex_mem_read = 1'b1;
    ex_rt = 5'd0;
    id_rs = 5'd0;
    step(0, 0, 0, 0, 0, "lu_r0");
    idle();
    id_valid    = 1'b1;
    id_rt       = 5'd13;
    id_uses_rt  = 1'b1;
    ex_mem_read = 1'b1;
    ex_rt       = 5'd13;
    step(1, 0, 0, 0, 0, "lu_rt");
    id_uses_rt = 1'b0;
    step(0, 0, 0, 0, 0, "lu_unused");
    id_uses_rt = 1'b1;
    id_valid   = 1'b0;
    step(0, 0, 0, 0, 0, "lu_novalid");
    idle();

    id_valid = 1'b1;
    id_is_md = 1'b1;
    step(0, 0, 1, 0, 0, "mult_start");
    id_is_md      = 1'b0;
    id_reads_hilo = 1'b1;
    for (int i = 1; i <= 4; i++) step(1, 0, 0, i == 4, 1, "mfhi_wait");
    step(0, 0, 0, 0, 0, "mfhi_go");
    idle();

    id_valid  = 1'b1;
    id_is_md  = 1'b1;
    id_is_div = 1'b1;
    step(0, 0, 1, 0, 0, "div_start");
    id_is_div = 1'b0;
    for (int i = 1; i <= 32; i++) step(1, 0, 0, i == 32, 1, "mult_wait");
    step(0, 0, 1, 0, 0, "mult_start2");
    idle();
    for (int i = 1; i <= 4; i++) step(0, 0, 0, i == 4, 1, "mult_run");
    step(0, 0, 0, 0, 0, "md_idle");

    load_use_on();
    branch_taken = 1'b1;
    step(1, 0, 0, 0, 0, "br_stall");
    ex_mem_read = 1'b0;
    step(0, 1, 0, 0, 0, "br_flush");
    idle();
    branch_taken = 1'b1;
    step(0, 1, 0, 0, 0, "br_novalid");
    idle();

    id_valid  = 1'b1;
    id_is_md  = 1'b1;
    id_is_div = 1'b1;
    step(0, 0, 1, 0, 0, "div2_start");
    idle();
    for (int i = 1; i <= 9; i++) step(0, 0, 0, 0, 1, "div2_run");
    rst_n  = 1'b0;
    sc_exp = 16'd0;
    step(0, 0, 0, 0, 0, "rst_mid");
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 0, "post_rst");

    load_use_on();
    for (int i = 0; i < 70000; i++) step(1, 0, 0, 0, 0, "sat");
    step(1, 0, 0, 0, 0, "sat_hold");
    idle();
    step(0, 0, 0, 0, 0, "sat_end");

    @(negedge clk);
    #1;
    if (q.size() != 0) chk("drain", q.size(), 0);
    if (sc_exp != 16'hFFFF) chk("sat_model", {16'd0, sc_exp}, 32'hFFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and multi-cycle sequencing controller for the 5-stage MIPS core. Sits beside the ID stage and decides, every cycle, whether the front end advances, stalls, or flushes. It detects load-use hazards against the EX stage and sequences the iterative mult/div unit: it issues the start pulse, counts its latency, and signals HI/LO completion. It holds back any later mult/div or mfhi/mflo until the unit is free, and it keeps a saturating stall-cycle performance counter.

## Interface
- MULT_CYCLES, 4, mult latency in cycles (>=1)
- DIV_CYCLES, 32, div latency in cycles (>=1)
- CNT_W, 6, latency counter width; both latencies must be < 2^CNT_W
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a valid instruction
- id_rs, id_rt  in  5 each  ID source register numbers
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads that operand
- id_is_md  in  1  ID instruction is mult/multu/div/divu
- id_is_div  in  1  qualifies id_is_md: 1 = div, 0 = mult
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- ex_mem_read  in  1  EX instruction is a load
- ex_rt  in  5  EX load destination
- branch_taken  in  1  branch/jump in ID resolved taken this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- idex_bubble  out  1  load a NOP into ID/EX
- ifid_flush  out  1  clear IF/ID (squash fetched instruction)
- md_start  out  1  one-cycle start pulse to mult/div unit
- md_done  out  1  one-cycle HI/LO write enable
- md_busy  out  1  mult/div operation in progress
- stall_cycles  out  16  saturating count of stall cycles

## Operation
- load_use = id_valid & ex_mem_read & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)).
- hilo_hz = id_valid & (id_is_md | id_reads_hilo) & (state == MD_BUSY).
- stall = load_use | hilo_hz.
- pc_write = ifid_write = ~stall.
- idex_bubble = stall.
- ifid_flush = branch_taken & ~stall. If a branch is taken during a stall, the flush is suppressed. The branch stays in ID and is re-resolved with fresh operands.
- FSM has two states, RUN and MD_BUSY.
  - RUN: md_start = id_valid & id_is_md & ~stall. On md_start, count <= id_is_div ? DIV_CYCLES : MULT_CYCLES, and the FSM goes to MD_BUSY.
  - MD_BUSY: count decrements every cycle. md_done = (count == 1). On md_done the FSM goes to RUN. md_start is never asserted in MD_BUSY.
- md_busy = (state == MD_BUSY), including the md_done cycle.
- stall_cycles increments on each cycle with stall = 1 and holds at 16'hFFFF.
- md_start, md_done, ifid_flush and idex_bubble are never asserted while id_valid = 0, except as follows:
  - md_done is driven by the counter regardless of ID contents.
  - ifid_flush follows branch_taken regardless of ID contents.

## Timing
- Reset (async assert, sync-safe release): state = RUN, count = 0, stall_cycles = 0.
- With id_valid = 0 and branch_taken = 0 during reset: pc_write = ifid_write = 1; all other outputs are 0.
- All stall, bubble and flush outputs are combinational from current inputs and state, in the same cycle. Only state, count and stall_cycles are registered.
- Load-use stall lasts exactly 1 cycle. The load moves to MEM and the hazard clears.
- Latency: md_start in cycle t gives md_done in cycle t+N, where N = MULT_CYCLES or DIV_CYCLES. md_busy is high in cycles t+1 through t+N.
- A dependent mfhi/mflo or next mult/div in ID stalls in cycles t+1 through t+N and proceeds in cycle t+N+1. Back-to-back mult/div therefore gives md_start at t and t+N+1.
- load_use and hilo_hz together: one stall; stall_cycles increments by 1.
- Reset asserted during MD_BUSY aborts the operation immediately; no md_done follows.
- N = 1: md_done occurs in cycle t+1 and the FSM returns to RUN at the end of that cycle.

## Test plan
- Load-use hazard: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1, id_valid=1 → pc_write=0, idex_bubble=1 for 1 cycle, stall_cycles=1. Repeat with ex_rt=0 → no stall.
- Mult then mfhi: mult in ID at cycle t → md_start at t, md_done at t+4. mfhi presented at t+1 → stalls cycles t+1..t+4 and issues at t+5.
- Back-to-back: div then mult → div md_start at t, md_done at t+32. Mult md_start at t+33, md_done at t+37.
- Branch vs stall: branch_taken=1 with load_use=1 → ifid_flush=0, stall=1. Next cycle branch_taken=1, no hazard → ifid_flush=1, pc_write=1.
- Reset mid-div: rst_n low at t+10 → md_busy=0 and stall_cycles=0 immediately. No md_done within 40 cycles after release.
- Saturation: hold a stall condition for 70000 cycles → stall_cycles reads 16'hFFFF and holds there.
